fp16_mul_arbiter: RTL and testbench
===================================

Name: fp16_mul_arbiter

Overview:
- Shares one fully pipelined FP16 multiplier (fp16_mult_wrapper, fixed latency MUL_LAT, no stall) between NREQ requesters.
- Typical requesters are the dt*x, dt*A and dt*B product streams of the SSM step.
- Arbitrates round-robin, issues one multiply per cycle and tracks the owner of each in-flight operation in a tag delay line.
- Routes each result back to its owner with a one-hot valid.

Parameters:
- DW, 16, operand/result width (FP16).
- MUL_LAT, 6, latency of the attached multiplier, in cycles from valid_in to valid_out; must be ≥1.
- NREQ, 3, number of requesters; 2..8.
- TW, 2, tag width; must be ≥ clog2(NREQ).

Ports:
- clk  in  1  clock.
- rstn  in  1  reset, asynchronous, active-low.
- req_valid_i  in  NREQ  per-requester operand-valid.
- req_ready_o  out  NREQ  one-hot grant; a request is accepted when valid and ready are both high at a rising edge.
- req_a_i  in  NREQ*DW  flattened operand A; requester k uses bits [k*DW +: DW].
- req_b_i  in  NREQ*DW  flattened operand B, same packing as req_a_i.
- mul_valid_o  out  1  to multiplier valid_in.
- mul_a_o  out  DW  to multiplier a.
- mul_b_o  out  DW  to multiplier b.
- mul_result_i  in  DW  from multiplier result.
- mul_valid_i  in  1  from multiplier valid_out.
- rsp_valid_o  out  NREQ  one-hot result-valid; there is no backpressure.
- rsp_data_o  out  DW  product, shared by all requesters.
- busy_o  out  1  high while any operation is in flight.
- err_o  out  1  sticky tag/valid misalignment flag.

Behaviour:
- Reset (rstn low, async):
  - req_ready_o, mul_valid_o, rsp_valid_o, busy_o and err_o go to 0.
  - mul_a_o, mul_b_o and rsp_data_o go to 0.
  - The round-robin pointer resets to 0.
  - All tag-line valid bits clear; in-flight operations are discarded and never answered.
  - The multiplier's own pipeline is reset by the same rstn.
- Arbitration (combinational):
  - Search req_valid_i starting at index ptr, wrapping modulo NREQ.
  - The first set bit wins; req_ready_o has exactly that bit set.
  - req_ready_o is all-zero when no request is valid, and is never asserted for an idle requester.
- Pointer update: on acceptance of requester g, ptr <= (g+1) mod NREQ. With no acceptance, ptr holds.
- Issue stage (registered):
  - Acceptance at edge T → mul_valid_o=1 in cycle T+1 with the accepted A/B.
  - Otherwise mul_valid_o=0; mul_a_o and mul_b_o hold their last value.
  - Throughput: one operation per cycle, with no bubbles under continuous demand.
- Tag line:
  - A shift register MUL_LAT stages deep, each stage holding a valid bit and a TW-bit tag.
  - Input is (mul_valid_o, issued tag); the head is aligned with mul_valid_i.
  - It advances every cycle; there is no stall.
- Response (registered):
  - When the head is valid and mul_valid_i=1: rsp_valid_o <= onehot(head tag) and rsp_data_o <= mul_result_i.
  - Otherwise rsp_valid_o <= 0 and rsp_data_o holds.
  - End-to-end latency is MUL_LAT+2 cycles: from the accepting edge T to rsp_valid_o high in cycle T+MUL_LAT+2.
- Ordering: results return in issue order; a requester's results return in its own acceptance order.
- Misalignment:
  - If mul_valid_i differs from the head valid bit, err_o <= 1 and stays set until reset.
  - In that case no response is generated for that cycle.
- busy_o is high when mul_valid_o is set, any tag stage is valid, or rsp_valid_o is set.
- Simultaneous events: a new acceptance, an issue, a retiring response and the pointer update may all occur in the same cycle, independently.
- Operand capture: a requester may change its operands the cycle after acceptance; operands are captured at the accepting edge.
- Arithmetic: none locally. Products are passed through bit-exact.

Test Plan:
- Single op: requester 1 presents A=0x4000, B=0x4200 for one accepted cycle → mul_valid_o in cycle T+1 with a=0x4000, b=0x4200; rsp_valid_o=3'b010 and rsp_data_o=0x4600 exactly at T+8 (MUL_LAT=6); busy_o falls the cycle after.
- Round-robin fairness: all three requesters hold valid for 9 cycles → grant order 0,1,2,0,1,2,0,1,2; responses arrive back-to-back with the same one-hot order and no gaps.
- Pointer skip/wrap: only requesters 0 and 2 valid with ptr=1 → grant 2, then 0, then 2; requester 1 is never granted.
- Mixed data: requester 0 sends 0xC000*0x3800 and requester 2 sends 0x3C00*0x3C00 in consecutive cycles → 0xBC00 to rsp_valid 001, then 0x3C00 to rsp_valid 100, on consecutive cycles.
- Reset mid-flight: assert rstn low 3 cycles after issuing 4 ops, then release → all outputs 0 during reset; no rsp_valid_o ever appears for the dropped ops; ptr=0 after release.
- Misalignment: the bench forces mul_valid_i high with an empty tag line → err_o=1 the next cycle and sticky, rsp_valid_o stays 0; err_o is cleared only by reset.

Source files
------------

// File: rtl/fp16_mul_arbiter.sv
// Round-robin arbiter sharing one pipelined FP16 multiplier among NREQ requesters; results routed back by tag.
// Latency: accept edge T -> mul_valid_o in cycle T+1 -> rsp_valid_o in cycle T+MUL_LAT+2.
// Backpressure: one-hot req_ready_o grants one requester per cycle; responses have no backpressure.
module fp16_mul_arbiter #(
   parameter int DW      = 16,
   parameter int MUL_LAT = 6,
   parameter int NREQ    = 3,
   parameter int TW      = 2
) (
   input  logic                clk,
   input  logic                rstn,
   input  logic [NREQ-1:0]     req_valid_i,
   output logic [NREQ-1:0]     req_ready_o,
   input  logic [NREQ*DW-1:0]  req_a_i,
   input  logic [NREQ*DW-1:0]  req_b_i,
   output logic                mul_valid_o,
   output logic [DW-1:0]       mul_a_o,
   output logic [DW-1:0]       mul_b_o,
   input  logic [DW-1:0]       mul_result_i,
   input  logic                mul_valid_i,
   output logic [NREQ-1:0]     rsp_valid_o,
   output logic [DW-1:0]       rsp_data_o,
   output logic                busy_o,
   output logic                err_o
);

   logic [TW-1:0]      ptr;
   logic [TW-1:0]      gnt_idx;
   logic               gnt_any;
   logic [NREQ-1:0]    grant;
   logic [TW-1:0]      issue_tag;
   logic [MUL_LAT-1:0] line_vld;
   logic [TW-1:0]      line_tag [MUL_LAT];
   logic               head_vld;
   logic [TW-1:0]      head_tag;
   logic               hit;

   // First valid requester at or after ptr, wrapping modulo NREQ.
   always_comb begin
      gnt_any = 1'b0;
      gnt_idx = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (!gnt_any && req_valid_i[(int'(ptr) + i) % NREQ]) begin
            gnt_any = 1'b1;
            gnt_idx = TW'((int'(ptr) + i) % NREQ);
         end
      end
   end

   assign grant       = gnt_any ? (NREQ'(1) << gnt_idx) : '0;
   assign req_ready_o = rstn ? grant : '0;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         ptr         <= '0;
         mul_valid_o <= 1'b0;
         mul_a_o     <= '0;
         mul_b_o     <= '0;
         issue_tag   <= '0;
      end else begin
         mul_valid_o <= gnt_any;
         if (gnt_any) begin
            mul_a_o   <= req_a_i[int'(gnt_idx)*DW +: DW];
            mul_b_o   <= req_b_i[int'(gnt_idx)*DW +: DW];
            issue_tag <= gnt_idx;
            ptr       <= (int'(gnt_idx) == NREQ-1) ? '0 : gnt_idx + TW'(1);
         end
      end
   end

   // Owner delay line; its head lines up with the multiplier's valid_out.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         line_vld <= '0;
         for (int k = 0; k < MUL_LAT; k++) line_tag[k] <= '0;
      end else begin
         line_vld[0] <= mul_valid_o;
         line_tag[0] <= issue_tag;
         for (int k = 1; k < MUL_LAT; k++) begin
            line_vld[k] <= line_vld[k-1];
            line_tag[k] <= line_tag[k-1];
         end
      end
   end

   assign head_vld = line_vld[MUL_LAT-1];
   assign head_tag = line_tag[MUL_LAT-1];
   assign hit      = head_vld & mul_valid_i;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         rsp_valid_o <= '0;
         rsp_data_o  <= '0;
         err_o       <= 1'b0;
      end else begin
         rsp_valid_o <= hit ? (NREQ'(1) << head_tag) : '0;
         if (hit) rsp_data_o <= mul_result_i;
         if (head_vld != mul_valid_i) err_o <= 1'b1;
      end
   end

   assign busy_o = mul_valid_o | (|line_vld) | (|rsp_valid_o);

endmodule

// File: tb/tb_fp16_mul_arbiter.sv
// Directed bench for fp16_mul_arbiter with a behavioural pipelined FP16 multiplier and a response scoreboard.
module tb_fp16_mul_arbiter;
   localparam int DW = 16, MUL_LAT = 6, NREQ = 3, TW = 2;

   logic               clk = 1'b0;
   logic               rstn = 1'b0;
   logic [NREQ-1:0]    req_valid_i = '0;
   logic [NREQ-1:0]    req_ready_o;
   logic [NREQ*DW-1:0] req_a_i = '0;
   logic [NREQ*DW-1:0] req_b_i = '0;
   logic               mul_valid_o;
   logic [DW-1:0]      mul_a_o, mul_b_o;
   logic [DW-1:0]      mul_result_i;
   logic               mul_valid_i;
   logic [NREQ-1:0]    rsp_valid_o;
   logic [DW-1:0]      rsp_data_o;
   logic               busy_o, err_o;

   int n_assert = 0;
   int n_fail   = 0;
   int cyc      = 0;
   logic force_mv = 1'b0;

   typedef struct {
      logic [NREQ-1:0] vld;
      logic [DW-1:0]   dat;
      int              cyc;
   } exp_t;
   exp_t sb[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   fp16_mul_arbiter #(.DW(DW), .MUL_LAT(MUL_LAT), .NREQ(NREQ), .TW(TW)) dut (
      .clk(clk), .rstn(rstn),
      .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
      .req_a_i(req_a_i), .req_b_i(req_b_i),
      .mul_valid_o(mul_valid_o), .mul_a_o(mul_a_o), .mul_b_o(mul_b_o),
      .mul_result_i(mul_result_i), .mul_valid_i(mul_valid_i),
      .rsp_valid_o(rsp_valid_o), .rsp_data_o(rsp_data_o),
      .busy_o(busy_o), .err_o(err_o)
   );

   // Normal-range FP16 multiply, truncating; exact for the directed operands.
   function automatic logic [15:0] fmul(input logic [15:0] a, input logic [15:0] b);
      logic [21:0] m;
      int          e;
      m = 22'({1'b1, a[9:0]}) * 22'({1'b1, b[9:0]});
      e = int'(a[14:10]) + int'(b[14:10]) - 15;
      if (m[21]) fmul = {a[15] ^ b[15], 5'(e + 1), m[20:11]};
      else       fmul = {a[15] ^ b[15], 5'(e), m[19:10]};
   endfunction

   logic [MUL_LAT-1:0] mv_pipe;
   logic [DW-1:0]      md_pipe [MUL_LAT];
   always @(posedge clk or negedge rstn) begin
      if (!rstn) mv_pipe <= '0;
      else begin
         mv_pipe[0] <= mul_valid_o;
         md_pipe[0] <= fmul(mul_a_o, mul_b_o);
         for (int k = 1; k < MUL_LAT; k++) begin
            mv_pipe[k] <= mv_pipe[k-1];
            md_pipe[k] <= md_pipe[k-1];
         end
      end
   end
   assign mul_valid_i  = mv_pipe[MUL_LAT-1] | force_mv;
   assign mul_result_i = md_pipe[MUL_LAT-1];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Response monitor: every retiring result must match the oldest expectation, in its exact cycle.
   always @(negedge clk) begin
      if (rstn) begin
         if (rsp_valid_o !== '0) begin
            if (sb.size() == 0) chk("unexpected_rsp", 32'(rsp_valid_o), 32'h0);
            else begin
               exp_t e;
               e = sb.pop_front();
               chk("rsp_valid", 32'(rsp_valid_o), 32'(e.vld));
               chk("rsp_data", 32'(rsp_data_o), 32'(e.dat));
               chk("rsp_cycle", 32'(cyc), 32'(e.cyc));
            end
         end else if (sb.size() > 0 && sb[0].cyc <= cyc) begin
            chk("missing_rsp", 32'(cyc), 32'(sb[0].cyc + 1000));
            void'(sb.pop_front());
         end
      end
   end

   task automatic set_op(input int k, input logic [15:0] a, input logic [15:0] b);
      req_a_i[k*DW +: DW] = a;
      req_b_i[k*DW +: DW] = b;
   endtask

   // Called at a falling edge with inputs set: checks the grant, books the result, advances one cycle.
   task automatic step(input logic [NREQ-1:0] exp_gnt);
      exp_t e;
      #1;
      chk("grant", 32'(req_ready_o), 32'(exp_gnt));
      for (int k = 0; k < NREQ; k++) begin
         if (exp_gnt[k] && req_valid_i[k]) begin
            e.vld = NREQ'(1) << k;
            e.dat = fmul(req_a_i[k*DW +: DW], req_b_i[k*DW +: DW]);
            e.cyc = cyc + MUL_LAT + 2;
            sb.push_back(e);
         end
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   initial begin
      idle(2);
      #1;
      chk("rst_ready", 32'(req_ready_o), 32'h0);
      chk("rst_mul_valid", 32'(mul_valid_o), 32'h0);
      chk("rst_rsp_valid", 32'(rsp_valid_o), 32'h0);
      chk("rst_busy", 32'(busy_o), 32'h0);
      chk("rst_err", 32'(err_o), 32'h0);
      rstn = 1'b1;
      idle(2);

      // Single op from requester 1 (ptr 0 -> 2)
      set_op(1, 16'h4000, 16'h4200);
      req_valid_i = 3'b010;
      step(3'b010);
      req_valid_i = '0;
      set_op(1, 16'h0000, 16'h0000);
      chk("single_mul_valid", 32'(mul_valid_o), 32'h1);
      chk("single_mul_a", 32'(mul_a_o), 32'h4000);
      chk("single_mul_b", 32'(mul_b_o), 32'h4200);
      idle(MUL_LAT + 1);
      chk("single_rsp_valid", 32'(rsp_valid_o), 32'h2);
      chk("single_rsp_data", 32'(rsp_data_o), 32'h4600);
      chk("single_busy_hi", 32'(busy_o), 32'h1);
      idle(1);
      chk("single_busy_lo", 32'(busy_o), 32'h0);
      chk("single_mul_a_hold", 32'(mul_a_o), 32'h4000);

      // Requester 0 alone from ptr 2 (wrap) -> ptr 1
      set_op(0, 16'h3E00, 16'h4100);
      req_valid_i = 3'b001;
      step(3'b001);

      // Skip/wrap: 0 and 2 valid with ptr 1 -> 2, 0, 2
      req_valid_i = 3'b101;
      set_op(0, 16'h3C00, 16'h4400); set_op(2, 16'h4200, 16'h3A00);
      step(3'b100);
      set_op(2, 16'h3D00, 16'h3D00);
      step(3'b001);
      set_op(0, 16'h0000, 16'h0000);
      step(3'b100);
      req_valid_i = '0;
      idle(MUL_LAT + 3);

      // Round-robin with fresh operands every cycle: 0,1,2 x3, back-to-back responses
      req_valid_i = 3'b111;
      for (int r = 0; r < 9; r++) begin
         for (int k = 0; k < NREQ; k++)
            set_op(k, 16'h3800 | 16'($urandom_range(0, 1023)), 16'h4000 | 16'($urandom_range(0, 1023)));
         step(NREQ'(1) << (r % NREQ));
      end
      req_valid_i = '0;
      idle(MUL_LAT + 3);

      // Mixed data on consecutive cycles (ptr 0)
      set_op(0, 16'hC000, 16'h3800);
      req_valid_i = 3'b001;
      step(3'b001);
      set_op(2, 16'h3C00, 16'h3C00);
      req_valid_i = 3'b100;
      step(3'b100);
      req_valid_i = '0;
      idle(MUL_LAT);
      chk("mixed_first", 32'(rsp_data_o), 32'hBC00);
      idle(1);
      chk("mixed_second", 32'(rsp_data_o), 32'h3C00);
      idle(2);

      // Reset mid-flight: 4 ops (0,1,2,0 -> ptr 1), then reset before any result returns
      req_valid_i = 3'b111;
      for (int r = 0; r < 4; r++) step(NREQ'(1) << (r % NREQ));
      req_valid_i = '0;
      idle(2);
      rstn = 1'b0;
      sb.delete();
      #1;
      chk("mid_rst_mul_valid", 32'(mul_valid_o), 32'h0);
      chk("mid_rst_mul_a", 32'(mul_a_o), 32'h0);
      chk("mid_rst_rsp_data", 32'(rsp_data_o), 32'h0);
      chk("mid_rst_busy", 32'(busy_o), 32'h0);
      idle(2);
      rstn = 1'b1;
      req_valid_i = 3'b111;
      #1;
      chk("post_rst_ptr0", 32'(req_ready_o), 32'h1);
      req_valid_i = '0;
      idle(MUL_LAT + 4);
      chk("post_rst_busy", 32'(busy_o), 32'h0);

      // Misalignment: multiplier valid with an empty tag line
      force_mv = 1'b1;
      @(posedge clk);
      #1;
      force_mv = 1'b0;
      chk("misalign_err", 32'(err_o), 32'h1);
      chk("misalign_no_rsp", 32'(rsp_valid_o), 32'h0);
      idle(4);
      chk("misalign_sticky", 32'(err_o), 32'h1);
      rstn = 1'b0;
      #1;
      chk("err_cleared", 32'(err_o), 32'h0);
      idle(1);
      rstn = 1'b1;
      idle(2);

      chk("scoreboard_empty", 32'(sb.size()), 32'h0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
